div_seq_ctrl: RTL

Sequencing controller for the 16-bit repeated-subtraction divider (quotient/remainder unit). Accepts operand pairs over a valid/ready handshake and drives the divider's operand and load inputs. Watches the divider's quotient/remainder outputs and captures the result on the exact cycle the remainder falls below the divisor. Presents the result over a second valid/ready handshake. Divide-by-zero, which the divider cannot terminate on, is handled here; a watchdog guards against runaway iteration.

---
 rtl/div_seq_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/div_seq_ctrl.sv
// Sequencing controller for a 16-bit repeated-subtraction divider: operand handshake,
// divider load/run control, result capture, divide-by-zero and watchdog handling.
module div_seq_ctrl #(
    parameter int unsigned MAX_ITER = 65535
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_x_i,
    input  logic [15:0] in_y_i,
    output logic [15:0] div_x_o,
    output logic [15:0] div_y_o,
    output logic        div_load_o,
    input  logic [15:0] div_quot_i,
    input  logic [15:0] div_rem_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [15:0] out_quot_o,
    output logic [15:0] out_rem_o,
    output logic        out_dbz_o,
    output logic        out_err_o
);

    localparam logic [15:0] IterLimit = MAX_ITER[15:0];

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StHold} state_e;

    state_e      state_q;
    logic        in_ready_q;
    logic        div_load_q;
    logic        out_valid_q;
    logic [15:0] div_x_q;
    logic [15:0] div_y_q;
    logic [15:0] iter_q;
    logic [15:0] quot_q;
    logic [15:0] rem_q;
    logic        dbz_q;
    logic        err_q;

    logic done;
    logic expired;

    assign done    = div_rem_i < div_y_q;
    assign expired = iter_q == IterLimit;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            div_load_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_x_q     <= 16'd0;
            div_y_q     <= 16'd0;
            iter_q      <= 16'd0;
            quot_q      <= 16'd0;
            rem_q       <= 16'd0;
            dbz_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        div_x_q    <= in_x_i;
                        div_y_q    <= in_y_i;
                        in_ready_q <= 1'b0;
                        // Zero divisor never terminates in the divider, so it is never released.
                        if (in_y_i == 16'd0) begin
                            state_q     <= StHold;
                            quot_q      <= 16'hFFFF;
                            rem_q       <= in_x_i;
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    iter_q     <= 16'd0;
                    div_load_q <= 1'b0;
                    state_q    <= StRun;
                end
                StRun: begin
                    if (!expired) begin
                        iter_q <= iter_q + 16'd1;
                    end
                    if (done || expired) begin
                        quot_q      <= div_quot_i;
                        rem_q       <= div_rem_i;
                        // Quotient must equal the number of observed iterations.
                        err_q       <= !done || (div_quot_i != iter_q);
                        out_valid_q <= 1'b1;
                        div_load_q  <= 1'b1;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        dbz_q       <= 1'b0;
                        err_q       <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign div_load_o  = div_load_q;
    assign out_valid_o = out_valid_q;
    assign div_x_o     = div_x_q;
    assign div_y_o     = div_y_q;
    assign out_quot_o  = quot_q;
    assign out_rem_o   = rem_q;
    assign out_dbz_o   = dbz_q;
    assign out_err_o   = err_q;

endmodule
